// File: rtl/captura_pkg.sv
// Shared definitions for the camera capture stage: pixel format codes,
// capture FSM states and the storage-width helper.
package captura_pkg;

  localparam int FMT_RGB332 = 0;
  localparam int FMT_RGB444 = 1;
  localparam int FMT_GRAY8  = 2;

  typedef enum logic [1:0] {
    WAIT_VS_HI = 2'd0,
    WAIT_VS_LO = 2'd1,
    ACTIVE     = 2'd2,
    DONE       = 2'd3
  } capState_e;

  // Stored pixel width for a given format: RGB444 needs 12 bits, the rest fit in 8.
  function automatic int dw_of(input int fmt);
    return (fmt == FMT_RGB444) ? 12 : 8;
  endfunction

endpackage

// File: rtl/captura_pix_convert.sv
// Combinational RGB565 to storage-format conversion (RGB332, RGB444 or GRAY8),
// chosen at elaboration time by PIX_FMT.
module captura_pix_convert
  import captura_pkg::*;
#(
  parameter int PIX_FMT = FMT_RGB332,
  parameter int DW      = dw_of(PIX_FMT)
) (
  input  logic [15:0]   pix_i,
  output logic [DW-1:0] pix_o
);

  logic [4:0]  red;
  logic [5:0]  green;
  logic [4:0]  blue;
  logic [7:0]  rgb332;
  logic [11:0] rgb444;
  logic [7:0]  gray8;

  assign red   = pix_i[15:11];
  assign green = pix_i[10:5];
  assign blue  = pix_i[4:0];

  assign rgb332 = {red[4:2], green[5:3], blue[4:3]};
  assign rgb444 = {red[4:1], green[5:2], blue[4:1]};
  // Red and blue are doubled to 6 bits so all three channels weigh roughly equally; max 62+63+62=187.
  assign gray8  = {2'b00, red, 1'b0} + {2'b00, green} + {2'b00, blue, 1'b0};

  // Pick the format requested for this build.
  always_comb begin
    pix_o = '0;
    case (PIX_FMT)
      FMT_RGB444: pix_o = DW'(rgb444);
      FMT_GRAY8:  pix_o = DW'(gray8);
      default:    pix_o = DW'(rgb332);
    endcase
  end

endmodule

// File: rtl/captura_datos_escalable.sv
// Camera capture stage: assembles RGB565 from the OV7670-style byte bus, converts it,
// crops to an IMG_W x IMG_H window and writes linear row-major addresses to the frame DPRAM.
// Optional 2x2 decimation is enabled by defining CAPTURA_DECIM_EN.
module captura_datos_escalable
  import captura_pkg::*;
#(
  parameter int IMG_W   = 176,
  parameter int IMG_H   = 144,
  parameter int PIX_FMT = FMT_RGB332,
  parameter int AW      = 15,
  parameter int DW      = dw_of(PIX_FMT)
) (
  input  logic          pclk,
  input  logic          rst,
  input  logic [7:0]    data,
  input  logic          href,
  input  logic          vsync,
  output logic [AW-1:0] DP_RAM_addr_out,
  output logic [DW-1:0] DP_RAM_data_out,
  output logic          DP_RAM_regW,
  output logic          frame_done,
  output logic          frame_short
);

`ifdef CAPTURA_DECIM_EN
  localparam int COL_W = $clog2(2 * IMG_W + 1);
  localparam int ROW_W = $clog2(2 * IMG_H + 1);
`else
  localparam int COL_W = $clog2(IMG_W + 1);
  localparam int ROW_W = $clog2(IMG_H + 1);
`endif
  localparam logic [AW-1:0] ROW_STEP = AW'(IMG_W);

  capState_e     state_q;
  logic          phase_q;
  logic          hrefPrev_q;
  logic [7:0]    hiByte_q;
  logic [COL_W-1:0] col_q;
  logic [ROW_W-1:0] row_q;
  logic [AW-1:0] rowBase_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] data_q;
  logic          regW_q;
  logic          done_q;
  logic          short_q;

  logic [DW-1:0]    pixConv;
  logic [COL_W-1:0] outCol;
  logic [ROW_W-1:0] outRow;
  logic             candidate;
  logic             inWindow;
  logic             writeOk;
  logic             lastPix;
  logic [AW-1:0]    writeAddr;
  logic [COL_W-1:0] colAfterPix;
  logic [ROW_W-1:0] rowAfterEnd;
  logic [AW-1:0]    rowBaseAfterEnd;

  captura_pix_convert #(
    .PIX_FMT(PIX_FMT),
    .DW     (DW)
  ) u_convert (
    .pix_i({hiByte_q, data}),
    .pix_o(pixConv)
  );

  // Window position of the pixel being completed and the counter values after a pixel / row end.
  always_comb begin
    outCol          = '0;
    outRow          = '0;
    candidate       = 1'b1;
    colAfterPix     = col_q;
    rowAfterEnd     = row_q;
    rowBaseAfterEnd = rowBase_q;
`ifdef CAPTURA_DECIM_EN
    outCol    = {1'b0, col_q[COL_W-1:1]};
    outRow    = {1'b0, row_q[ROW_W-1:1]};
    candidate = ~col_q[0] & ~row_q[0];
`else
    outCol    = col_q;
    outRow    = row_q;
`endif
    inWindow  = (outCol < COL_W'(IMG_W)) && (outRow < ROW_W'(IMG_H));
    writeOk   = candidate & inWindow;
    lastPix   = (outCol == COL_W'(IMG_W - 1)) && (outRow == ROW_W'(IMG_H - 1));
    writeAddr = rowBase_q + AW'(outCol);
`ifdef CAPTURA_DECIM_EN
    if (col_q < COL_W'(2 * IMG_W)) colAfterPix = col_q + COL_W'(1);
    if (row_q < ROW_W'(2 * IMG_H)) rowAfterEnd = row_q + ROW_W'(1);
    if (row_q[0] && (outRow < ROW_W'(IMG_H - 1))) rowBaseAfterEnd = rowBase_q + ROW_STEP;
`else
    if (writeOk) colAfterPix = col_q + COL_W'(1);
    if (row_q < ROW_W'(IMG_H)) rowAfterEnd = row_q + ROW_W'(1);
    if (row_q < ROW_W'(IMG_H - 1)) rowBaseAfterEnd = rowBase_q + ROW_STEP;
`endif
  end

  // Capture FSM with byte pairing, cropping, address generation and registered write/frame pulses.
  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q    <= WAIT_VS_HI;
      phase_q    <= 1'b0;
      hrefPrev_q <= 1'b0;
      hiByte_q   <= '0;
      col_q      <= '0;
      row_q      <= '0;
      rowBase_q  <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      regW_q     <= 1'b0;
      done_q     <= 1'b0;
      short_q    <= 1'b0;
    end else begin
      regW_q  <= 1'b0;
      done_q  <= 1'b0;
      short_q <= 1'b0;
      case (state_q)
        WAIT_VS_HI: begin
          if (vsync) state_q <= WAIT_VS_LO;
        end
        WAIT_VS_LO: begin
          if (!vsync) begin
            state_q    <= ACTIVE;
            phase_q    <= 1'b0;
            hrefPrev_q <= 1'b0;
            col_q      <= '0;
            row_q      <= '0;
            rowBase_q  <= '0;
          end
        end
        ACTIVE: begin
          if (vsync) begin
            state_q    <= WAIT_VS_LO;
            done_q     <= 1'b1;
            short_q    <= 1'b1;
            phase_q    <= 1'b0;
            hrefPrev_q <= 1'b0;
          end else begin
            hrefPrev_q <= href;
            if (href) begin
              phase_q <= ~phase_q;
              if (!phase_q) begin
                hiByte_q <= data;
              end else begin
                col_q <= colAfterPix;
                if (writeOk) begin
                  regW_q <= 1'b1;
                  addr_q <= writeAddr;
                  data_q <= pixConv;
                  if (lastPix) begin
                    done_q  <= 1'b1;
                    state_q <= DONE;
                  end
                end
              end
            end else begin
              phase_q <= 1'b0;
              if (hrefPrev_q) begin
                col_q     <= '0;
                row_q     <= rowAfterEnd;
                rowBase_q <= rowBaseAfterEnd;
              end
            end
          end
        end
        DONE: begin
          if (vsync) state_q <= WAIT_VS_LO;
        end
        default: state_q <= WAIT_VS_HI;
      endcase
    end
  end

  assign DP_RAM_addr_out = addr_q;
  assign DP_RAM_data_out = data_q;
  assign DP_RAM_regW     = regW_q;
  assign frame_done      = done_q;
  assign frame_short     = short_q;

endmodule

// File: tb/tb_captura_datos_escalable.sv
// Directed testbench for captura_datos_escalable: three 4x2 instances (RGB332, RGB444, GRAY8)
// share one pixel bus; with CAPTURA_DECIM_EN a 2x2 decimating instance is exercised instead.
module tb_captura_datos_escalable;

  logic        pclk;
  logic        rst;
  logic        href;
  logic        vsync;
  logic [7:0]  data;

  logic [2:0]  addr0, addr1, addr2;
  logic [7:0]  dat0;
  logic [11:0] dat1;
  logic [7:0]  dat2;
  logic        regW0, regW1, regW2;
  logic        done0, done1, done2;
  logic        short0, short1, short2;

  int assertCount = 0;
  int failCount   = 0;

  logic [7:0] rowBuf [16];

  typedef struct {
    logic        regW;
    logic [2:0]  addr;
    logic [7:0]  d0;
    logic [11:0] d1;
    logic [7:0]  d2;
    logic        done;
    logic        shrt;
  } ev_t;

  ev_t evQ[$];
  ev_t recEv;

  captura_datos_escalable #(.IMG_W(4), .IMG_H(2), .PIX_FMT(0), .AW(3)) dut0 (
    .pclk(pclk), .rst(rst), .data(data), .href(href), .vsync(vsync),
    .DP_RAM_addr_out(addr0), .DP_RAM_data_out(dat0), .DP_RAM_regW(regW0),
    .frame_done(done0), .frame_short(short0));

  captura_datos_escalable #(.IMG_W(4), .IMG_H(2), .PIX_FMT(1), .AW(3)) dut1 (
    .pclk(pclk), .rst(rst), .data(data), .href(href), .vsync(vsync),
    .DP_RAM_addr_out(addr1), .DP_RAM_data_out(dat1), .DP_RAM_regW(regW1),
    .frame_done(done1), .frame_short(short1));

  captura_datos_escalable #(.IMG_W(4), .IMG_H(2), .PIX_FMT(2), .AW(3)) dut2 (
    .pclk(pclk), .rst(rst), .data(data), .href(href), .vsync(vsync),
    .DP_RAM_addr_out(addr2), .DP_RAM_data_out(dat2), .DP_RAM_regW(regW2),
    .frame_done(done2), .frame_short(short2));

`ifdef CAPTURA_DECIM_EN
  logic [1:0] addrD;
  logic [7:0] datD;
  logic       regWD, doneD, shortD;
  logic [1:0] dAddr[$];
  logic [7:0] dData[$];
  logic       dDone[$];

  captura_datos_escalable #(.IMG_W(2), .IMG_H(2), .PIX_FMT(0), .AW(2)) dutD (
    .pclk(pclk), .rst(rst), .data(data), .href(href), .vsync(vsync),
    .DP_RAM_addr_out(addrD), .DP_RAM_data_out(datD), .DP_RAM_regW(regWD),
    .frame_done(doneD), .frame_short(shortD));

  // Log every write of the decimating instance.
  always @(negedge pclk) begin
    if (regWD === 1'b1) begin
      dAddr.push_back(addrD);
      dData.push_back(datD);
      dDone.push_back(doneD);
    end
  end
`endif

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Log every write or frame pulse of the three format instances, sampled mid-cycle.
  always @(negedge pclk) begin
    if (regW0 === 1'b1 || done0 === 1'b1) begin
      recEv.regW = regW0;
      recEv.addr = addr0;
      recEv.d0   = dat0;
      recEv.d1   = dat1;
      recEv.d2   = dat2;
      recEv.done = done0;
      recEv.shrt = short0;
      evQ.push_back(recEv);
    end
  end

  // Hard stop if the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation did not finish within time limit");
    $fatal(1, "[TB] timeout");
  end

  task automatic tick();
    @(negedge pclk);
  endtask

  task automatic idle(input int n);
    href = 1'b0;
    data = 8'h00;
    repeat (n) tick();
  endtask

  task automatic vsyncPulse();
    href  = 1'b0;
    vsync = 1'b1;
    repeat (3) tick();
    vsync = 1'b0;
    repeat (2) tick();
  endtask

  task automatic sendRow(input int nBytes);
    for (int i = 0; i < nBytes; i++) begin
      href = 1'b1;
      data = rowBuf[i];
      tick();
    end
    idle(3);
  endtask

  task automatic loadPattern();
    rowBuf[0] = 8'hF8; rowBuf[1] = 8'h00; rowBuf[2]  = 8'h07; rowBuf[3]  = 8'hE0;
    rowBuf[4] = 8'h00; rowBuf[5] = 8'h1F; rowBuf[6]  = 8'hFF; rowBuf[7]  = 8'hFF;
    rowBuf[8] = 8'hF8; rowBuf[9] = 8'h00; rowBuf[10] = 8'h07; rowBuf[11] = 8'hE0;
  endtask

  task automatic test_reset();
    rst = 1'b1; href = 1'b0; vsync = 1'b0; data = 8'h00;
    repeat (3) tick();
    assertCount++;
    if (addr0 !== 3'd0 || dat0 !== 8'h00 || regW0 !== 1'b0 || done0 !== 1'b0 || short0 !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL reset_outputs got addr=%0d data=%h regW=%b done=%b short=%b required all 0",
               addr0, dat0, regW0, done0, short0);
    end
    assertCount++;
    if (dat1 !== 12'h000 || dat2 !== 8'h00) begin
      failCount++;
      $display("[TB] FAIL reset_data_fmt got d1=%h d2=%h required 000/00", dat1, dat2);
    end
    rst = 1'b0;
    repeat (2) tick();
  endtask

`ifndef CAPTURA_DECIM_EN
  task automatic test_frame();
    logic [7:0]  e0 [4];
    logic [11:0] e1 [4];
    logic [7:0]  e2 [4];
    e0[0] = 8'hE0;  e0[1] = 8'h1C;  e0[2] = 8'h03;  e0[3] = 8'hFF;
    e1[0] = 12'hF00; e1[1] = 12'h0F0; e1[2] = 12'h00F; e1[3] = 12'hFFF;
    e2[0] = 8'h3E;  e2[1] = 8'h3F;  e2[2] = 8'h3E;  e2[3] = 8'hBB;
    loadPattern();
    evQ.delete();
    vsyncPulse();
    sendRow(8);
    sendRow(8);
    idle(3);
    assertCount++;
    if (evQ.size() != 8) begin
      failCount++;
      $display("[TB] FAIL frame_events got %0d required 8", evQ.size());
    end
    for (int i = 0; i < evQ.size() && i < 8; i++) begin
      assertCount++;
      if (evQ[i].regW !== 1'b1 || evQ[i].addr !== 3'(i) || evQ[i].d0 !== e0[i%4] ||
          evQ[i].d1 !== e1[i%4] || evQ[i].d2 !== e2[i%4] ||
          evQ[i].done !== 1'(i == 7) || evQ[i].shrt !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL frame_write%0d got addr=%0d d0=%h d1=%h d2=%h done=%b short=%b required addr=%0d d0=%h d1=%h d2=%h done=%b short=0",
                 i, evQ[i].addr, evQ[i].d0, evQ[i].d1, evQ[i].d2, evQ[i].done, evQ[i].shrt,
                 i, e0[i%4], e1[i%4], e2[i%4], (i == 7));
      end
    end
    assertCount++;
    if (addr0 !== 3'd7 || dat0 !== 8'hFF || regW0 !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL frame_hold got addr=%0d data=%h regW=%b required 7/ff/0", addr0, dat0, regW0);
    end
    // Rows after completion are ignored.
    evQ.delete();
    sendRow(8);
    assertCount++;
    if (evQ.size() != 0) begin
      failCount++;
      $display("[TB] FAIL done_ignores_rows got %0d events required 0", evQ.size());
    end
  endtask

  task automatic test_formats();
    rowBuf[0] = 8'hFF; rowBuf[1] = 8'hFF; rowBuf[2] = 8'h00; rowBuf[3] = 8'h00;
    rowBuf[4] = 8'hF8; rowBuf[5] = 8'h00; rowBuf[6] = 8'h07; rowBuf[7] = 8'hE0;
    evQ.delete();
    vsyncPulse();
    sendRow(8);
    sendRow(8);
    assertCount++;
    if (evQ.size() < 4) begin
      failCount++;
      $display("[TB] FAIL formats_events got %0d required 8", evQ.size());
    end else begin
      assertCount++;
      if (evQ[0].d2 !== 8'hBB) begin
        failCount++;
        $display("[TB] FAIL gray_white got %h required bb", evQ[0].d2);
      end
      assertCount++;
      if (evQ[1].d2 !== 8'h00 || evQ[1].d1 !== 12'h000 || evQ[1].d0 !== 8'h00) begin
        failCount++;
        $display("[TB] FAIL black_all got d0=%h d1=%h d2=%h required 00/000/00", evQ[1].d0, evQ[1].d1, evQ[1].d2);
      end
      assertCount++;
      if (evQ[2].d1 !== 12'hF00) begin
        failCount++;
        $display("[TB] FAIL rgb444_red got %h required f00", evQ[2].d1);
      end
      assertCount++;
      if (evQ[3].d2 !== 8'h3F || evQ[3].d1 !== 12'h0F0) begin
        failCount++;
        $display("[TB] FAIL green_fmt got d1=%h d2=%h required 0f0/3f", evQ[3].d1, evQ[3].d2);
      end
    end
  endtask

  task automatic test_crop();
    logic [2:0] eA [6];
    logic [7:0] dA [6];
    logic [2:0] eB [6];
    logic [7:0] dB [6];
    eA[0] = 3'd0; eA[1] = 3'd1; eA[2] = 3'd2; eA[3] = 3'd3; eA[4] = 3'd4; eA[5] = 3'd5;
    dA[0] = 8'hE0; dA[1] = 8'h1C; dA[2] = 8'h03; dA[3] = 8'hFF; dA[4] = 8'hE0; dA[5] = 8'h1C;
    eB[0] = 3'd0; eB[1] = 3'd1; eB[2] = 3'd4; eB[3] = 3'd5; eB[4] = 3'd6; eB[5] = 3'd7;
    dB[0] = 8'hE0; dB[1] = 8'h1C; dB[2] = 8'hE0; dB[3] = 8'h1C; dB[4] = 8'h03; dB[5] = 8'hFF;
    loadPattern();
    evQ.delete();
    vsyncPulse();
    sendRow(12);
    sendRow(5);
    vsyncPulse();
    assertCount++;
    if (evQ.size() != 7) begin
      failCount++;
      $display("[TB] FAIL crop_events got %0d required 7", evQ.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        assertCount++;
        if (evQ[i].regW !== 1'b1 || evQ[i].addr !== eA[i] || evQ[i].d0 !== dA[i] || evQ[i].done !== 1'b0) begin
          failCount++;
          $display("[TB] FAIL crop_write%0d got addr=%0d d0=%h done=%b required addr=%0d d0=%h done=0",
                   i, evQ[i].addr, evQ[i].d0, evQ[i].done, eA[i], dA[i]);
        end
      end
      assertCount++;
      if (evQ[6].regW !== 1'b0 || evQ[6].done !== 1'b1 || evQ[6].shrt !== 1'b1) begin
        failCount++;
        $display("[TB] FAIL crop_abort got regW=%b done=%b short=%b required 0/1/1", evQ[6].regW, evQ[6].done, evQ[6].shrt);
      end
    end
    evQ.delete();
    sendRow(4);
    sendRow(8);
    assertCount++;
    if (evQ.size() != 6) begin
      failCount++;
      $display("[TB] FAIL shortrow_events got %0d required 6", evQ.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        assertCount++;
        if (evQ[i].addr !== eB[i] || evQ[i].d0 !== dB[i] || evQ[i].done !== 1'(i == 5) || evQ[i].shrt !== 1'b0) begin
          failCount++;
          $display("[TB] FAIL shortrow_write%0d got addr=%0d d0=%h done=%b short=%b required addr=%0d d0=%h done=%b short=0",
                   i, evQ[i].addr, evQ[i].d0, evQ[i].done, evQ[i].shrt, eB[i], dB[i], (i == 5));
        end
      end
    end
  endtask

  task automatic test_short_frame();
    loadPattern();
    evQ.delete();
    vsyncPulse();
    sendRow(8);
    sendRow(2);
    vsyncPulse();
    assertCount++;
    if (evQ.size() != 6) begin
      failCount++;
      $display("[TB] FAIL short_events got %0d required 6", evQ.size());
    end else begin
      assertCount++;
      if (evQ[4].addr !== 3'd4 || evQ[4].regW !== 1'b1 || evQ[4].done !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL short_last_write got addr=%0d regW=%b done=%b required 4/1/0", evQ[4].addr, evQ[4].regW, evQ[4].done);
      end
      assertCount++;
      if (evQ[5].regW !== 1'b0 || evQ[5].done !== 1'b1 || evQ[5].shrt !== 1'b1) begin
        failCount++;
        $display("[TB] FAIL short_flags got regW=%b done=%b short=%b required 0/1/1", evQ[5].regW, evQ[5].done, evQ[5].shrt);
      end
    end
    evQ.delete();
    sendRow(8);
    sendRow(8);
    assertCount++;
    if (evQ.size() != 8 || evQ[0].addr !== 3'd0 || evQ[7].addr !== 3'd7 || evQ[7].done !== 1'b1 || evQ[7].shrt !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL restart_frame got %0d events required 8 events addr 0..7 done at last short 0", evQ.size());
    end
  endtask

  task automatic test_reset_mid_row();
    loadPattern();
    vsyncPulse();
    href = 1'b1; data = 8'hF8; tick();
    data = 8'h00; tick();
    rst = 1'b1; data = 8'h07; tick();
    assertCount++;
    if (addr0 !== 3'd0 || dat0 !== 8'h00 || regW0 !== 1'b0 || done0 !== 1'b0 || short0 !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL midrow_reset got addr=%0d data=%h regW=%b done=%b short=%b required all 0",
               addr0, dat0, regW0, done0, short0);
    end
    rst = 1'b0;
    idle(2);
    evQ.delete();
    sendRow(8);
    sendRow(8);
    assertCount++;
    if (evQ.size() != 0) begin
      failCount++;
      $display("[TB] FAIL no_capture_before_vsync got %0d events required 0", evQ.size());
    end
    evQ.delete();
    vsyncPulse();
    sendRow(8);
    sendRow(8);
    assertCount++;
    if (evQ.size() != 8 || evQ[0].addr !== 3'd0 || evQ[0].d0 !== 8'hE0 || evQ[7].addr !== 3'd7 || evQ[7].done !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL post_reset_frame got %0d events required 8 events from addr 0 with done at addr 7", evQ.size());
    end
  endtask
`else
  task automatic test_decim();
    logic [7:0] eD [4];
    eD[0] = 8'h00; eD[1] = 8'h08; eD[2] = 8'h40; eD[3] = 8'h48;
    dAddr.delete(); dData.delete(); dDone.delete();
    vsyncPulse();
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        rowBuf[2*c]   = {r[2:0], 2'b00, c[2:0]};
        rowBuf[2*c+1] = 8'h00;
      end
      sendRow(8);
    end
    assertCount++;
    if (dAddr.size() != 4) begin
      failCount++;
      $display("[TB] FAIL decim_writes got %0d required 4", dAddr.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        assertCount++;
        if (dAddr[i] !== 2'(i) || dData[i] !== eD[i] || dDone[i] !== 1'(i == 3)) begin
          failCount++;
          $display("[TB] FAIL decim_write%0d got addr=%0d data=%h done=%b required addr=%0d data=%h done=%b",
                   i, dAddr[i], dData[i], dDone[i], i, eD[i], (i == 3));
        end
      end
    end
  endtask
`endif

  initial begin
    $display("[TB] captura_datos_escalable directed test start");
    test_reset();
`ifdef CAPTURA_DECIM_EN
    test_decim();
`else
    test_frame();
    test_formats();
    test_crop();
    test_short_frame();
    test_reset_mid_row();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
